// File: rtl/shifter_pkg.sv
// Shared types for the multi-cycle shifter: shift modes and controller states.
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shifter_state_t;

endpackage

// File: rtl/shift_step_unit.sv
// One iteration of the shifter: moves data by s (0..STEP) positions per the mode.
module shift_step_unit
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    localparam int unsigned S_W  = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [S_W-1:0]   s,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] shifted_c
);

    logic [2*WIDTH-1:0] rot_wide_c;

    // Rotation: shift a doubled copy left, the upper half holds the wrapped word.
    always_comb begin
        rot_wide_c = {data, data} << s;
        shifted_c  = data;
        unique case (mode)
            SLL:     shifted_c = data << s;
            SRL:     shifted_c = data >> s;
            SRA:     shifted_c = WIDTH'($signed(data) >>> s);
            ROL:     shifted_c = rot_wide_c[2*WIDTH-1:WIDTH];
            default: shifted_c = data;
        endcase
    end

endmodule

// File: rtl/param_seq_shifter.sv
// Iterative WIDTH-bit shifter: up to STEP positions per clock behind valid/ready.
module param_seq_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP   = 1,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned S_W = $clog2(STEP + 1);

    shifter_state_t   state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] rem_q;
    shift_mode_t      mode_q;

    logic             accept_c;
    logic [AMT_W-1:0] step_amt_c;
    logic [AMT_W-1:0] rem_next_c;
    logic [WIDTH-1:0] shifted_c;

    assign accept_c = in_valid && (state_q == IDLE);

    // Iteration size: min(remaining, STEP); never exceeds WIDTH-1 so fits AMT_W.
    always_comb begin
        step_amt_c = rem_q;
        if (32'(rem_q) > STEP) begin
            step_amt_c = AMT_W'(STEP);
        end
        rem_next_c = rem_q - step_amt_c;
    end

    shift_step_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data      (data_q),
        .s         (S_W'(step_amt_c)),
        .mode      (mode_q),
        .shifted_c (shifted_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_next_c == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand is captured once at accept; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            rem_q  <= '0;
            mode_q <= SLL;
        end else if (accept_c) begin
            data_q <= in_data;
            rem_q  <= in_amt;
            mode_q <= shift_mode_t'(in_mode);
        end else if (state_q == SHIFT) begin
            data_q <= shifted_c;
            rem_q  <= rem_next_c;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_param_seq_shifter.sv
// Bench for param_seq_shifter: STEP=1 and STEP=2 instances, vector table, corners, random ops.
module tb_param_seq_shifter;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] in_data  [2];
    logic [2:0] in_amt   [2];
    logic [1:0] in_mode  [2];
    logic [7:0] out_data [2];

    int checks   = 0;
    int failures = 0;

    param_seq_shifter #(.WIDTH(8), .STEP(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_amt(in_amt[0]), .in_mode(in_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0])
    );

    param_seq_shifter #(.WIDTH(8), .STEP(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_amt(in_amt[1]), .in_mode(in_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: bit-by-bit definition of each mode.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input logic [1:0] m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            case (m)
                2'b00:   r[i] = (i >= amt) ? d[i-amt] : 1'b0;
                2'b01:   r[i] = (i + amt < 8) ? d[i+amt] : 1'b0;
                2'b10:   r[i] = (i + amt < 8) ? d[i+amt] : d[7];
                default: r[i] = d[(i - amt + 8) % 8];
            endcase
        end
        return r;
    endfunction

    // Issue one op on unit u at a negedge; returns result and edges from accept to out_valid.
    task automatic do_op(input int u, input logic [7:0] d, input logic [2:0] a,
                         input logic [1:0] m, output logic [7:0] res, output int lat);
        chk($sformatf("u%0d in_ready before op", u), 32'(in_ready[u]), 32'd1);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_amt[u]   = a;
        in_mode[u]  = m;
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_data[u]  = ~d;
        in_amt[u]   = 3'($urandom_range(0, 7));
        in_mode[u]  = ~m;
        lat = 0;
        while (!out_valid[u] && lat < 40) begin
            chk($sformatf("u%0d busy in flight", u), 32'(busy[u]), 32'd1);
            chk($sformatf("u%0d in_ready in flight", u), 32'(in_ready[u]), 32'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid[u]) begin
            chk($sformatf("u%0d out_valid timeout", u), 32'(out_valid[u]), 32'd1);
        end
        res = out_data[u];
        chk($sformatf("u%0d busy at done", u), 32'(busy[u]), 32'd1);
        out_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[u] = 1'b0;
        chk($sformatf("u%0d in_ready after handshake", u), 32'(in_ready[u]), 32'd1);
        chk($sformatf("u%0d out_valid after handshake", u), 32'(out_valid[u]), 32'd0);
    endtask

    typedef struct {
        int         unit;
        logic [7:0] data;
        logic [2:0] amt;
        logic [1:0] mode;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] res, hold;
        int         lat;

        vecs[0] = '{0, 8'h96, 3'd3, 2'b00, 8'hB0, 3};
        vecs[1] = '{0, 8'h96, 3'd2, 2'b10, 8'hE5, 2};
        vecs[2] = '{0, 8'h96, 3'd2, 2'b01, 8'h25, 2};
        vecs[3] = '{0, 8'h96, 3'd3, 2'b11, 8'hB4, 3};
        vecs[4] = '{0, 8'h5A, 3'd0, 2'b10, 8'h5A, 0};
        vecs[5] = '{1, 8'h01, 3'd5, 2'b00, 8'h20, 3};
        vecs[6] = '{1, 8'h80, 3'd7, 2'b01, 8'h01, 4};

        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        for (int u = 0; u < 2; u++) begin
            in_data[u] = '0;
            in_amt[u]  = '0;
            in_mode[u] = '0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d reset in_ready", u), 32'(in_ready[u]), 32'd1);
            chk($sformatf("u%0d reset out_valid", u), 32'(out_valid[u]), 32'd0);
            chk($sformatf("u%0d reset out_data", u), 32'(out_data[u]), 32'd0);
            chk($sformatf("u%0d reset busy", u), 32'(busy[u]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].unit, vecs[i].data, vecs[i].amt, vecs[i].mode, res, lat);
            chk($sformatf("vec%0d data", i), 32'(res), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
        end

        // Backpressure on an amt=0 result, with a spurious offer while stalled.
        in_valid[0] = 1'b1; in_data[0] = 8'h5A; in_amt[0] = 3'd0; in_mode[0] = 2'b01;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("bp out_valid next cycle", 32'(out_valid[0]), 32'd1);
        hold = out_data[0];
        chk("bp data", 32'(hold), 32'h5A);
        for (int c = 0; c < 5; c++) begin
            in_valid[0] = (c == 2);
            in_data[0]  = 8'hC3;
            in_amt[0]   = 3'd4;
            @(posedge clk);
            @(negedge clk);
            chk("bp out_data stable", 32'(out_data[0]), 32'(hold));
            chk("bp out_valid held", 32'(out_valid[0]), 32'd1);
            chk("bp in_ready low", 32'(in_ready[0]), 32'd0);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("bp in_ready after release", 32'(in_ready[0]), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp no phantom op", 32'(out_valid[0]), 32'd0);
        chk("bp no phantom busy", 32'(busy[0]), 32'd0);

        // Reset in the middle of a SHIFT.
        in_valid[0] = 1'b1; in_data[0] = 8'hFF; in_amt[0] = 3'd7; in_mode[0] = 2'b00;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid[0]), 32'd0);
        chk("abort out_data", 32'(out_data[0]), 32'd0);
        chk("abort in_ready", 32'(in_ready[0]), 32'd1);
        chk("abort busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(0, 8'h03, 3'd1, 2'b00, res, lat);
        chk("post-abort data", 32'(res), 32'h06);
        chk("post-abort latency", lat, 1);

        // Random operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            int         u;
            logic [7:0] d;
            logic [2:0] a;
            logic [1:0] m;
            u = i % 2;
            d = 8'($urandom);
            a = 3'($urandom_range(0, 7));
            m = 2'($urandom_range(0, 3));
            do_op(u, d, a, m, res, lat);
            chk($sformatf("rand%0d u%0d d=%02h a=%0d m=%0d data", i, u, d, a, m),
                32'(res), 32'(ref_shift(d, int'(a), m)));
            chk($sformatf("rand%0d latency", i), lat, (int'(a) + u) / (u + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
